// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: CPU-side initiator of the UART character interface.
// Buffers TX/RX bytes in small FIFOs and drives the UART wrn/rdn strobes on clk16x.

module uart_host_ctrl_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 3
) (
  input  logic         clk16x,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk16x) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
      mem  <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end
endmodule

module uart_host_ctrl #(
  parameter int unsigned AW  = 3,
  parameter int unsigned STB = 2,
  parameter int unsigned TMO = 64
) (
  input  logic          clk16x,
  input  logic          clr,
  input  logic          tx_valid,
  input  logic [7:0]    tx_data,
  output logic          tx_ready,
  output logic          rx_valid,
  output logic [7:0]    rx_data,
  output logic          rx_perr,
  output logic          rx_ferr,
  input  logic          rx_ready,
  output logic          wrn,
  output logic [7:0]    d_in,
  input  logic          t_empty,
  output logic          rdn,
  input  logic [7:0]    d_out,
  input  logic          r_ready,
  input  logic          parity_error,
  input  logic          frame_error,
  output logic [AW:0]   tx_level,
  output logic          tmo_err
);
  localparam logic [3:0] STB_LAST = 4'(STB - 1);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  typedef enum logic [1:0] {T_IDLE, T_STB, T_ACK} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_STB, R_ACK} rx_state_t;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  logic       tx_full;
  logic       tx_empty;
  logic       tx_push;
  logic       tx_pop;
  logic [7:0] tx_head;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_push;
  logic       rx_pop;
  rx_entry_t  rx_wdata;
  rx_entry_t  rx_head;

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_data  = rx_head.data;
  assign rx_perr  = rx_head.perr;
  assign rx_ferr  = rx_head.ferr;
  assign rx_wdata = '{ferr: frame_error, perr: parity_error, data: d_out};

  uart_host_ctrl_fifo #(.W(8), .AW(AW)) u_tx_fifo (
    .clk16x (clk16x),
    .clr    (clr),
    .push   (tx_push),
    .wdata  (tx_data),
    .pop    (tx_pop),
    .rdata  (tx_head),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  uart_host_ctrl_fifo #(.W($bits(rx_entry_t)), .AW(AW)) u_rx_fifo (
    .clk16x (clk16x),
    .clr    (clr),
    .push   (rx_push),
    .wdata  (rx_wdata),
    .pop    (rx_pop),
    .rdata  (rx_head),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  // TX FSM: load head into d_in, pulse wrn, wait for the UART to go busy.
  tx_state_t  tx_state;
  tx_state_t  tx_state_nx;
  logic [3:0] tx_stb;
  logic [3:0] tx_stb_nx;
  logic [7:0] tx_tmo;
  logic [7:0] tx_tmo_nx;
  logic       wrn_nx;
  logic [7:0] d_in_nx;
  logic       tx_timeout;

  always_ff @(posedge clk16x) begin
    if (clr) begin
      tx_state <= T_IDLE;
      tx_stb   <= '0;
      tx_tmo   <= '0;
      wrn      <= 1'b1;
      d_in     <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_stb   <= tx_stb_nx;
      tx_tmo   <= tx_tmo_nx;
      wrn      <= wrn_nx;
      d_in     <= d_in_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_stb_nx   = tx_stb;
    tx_tmo_nx   = tx_tmo;
    wrn_nx      = wrn;
    d_in_nx     = d_in;
    tx_pop      = 1'b0;
    tx_timeout  = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!tx_empty && t_empty) begin
          tx_pop      = 1'b1;
          d_in_nx     = tx_head;
          wrn_nx      = 1'b0;
          tx_stb_nx   = '0;
          tx_state_nx = T_STB;
        end
      end
      T_STB: begin
        if (tx_stb == STB_LAST) begin
          wrn_nx      = 1'b1;
          tx_tmo_nx   = '0;
          tx_state_nx = T_ACK;
        end else begin
          tx_stb_nx = tx_stb + 4'd1;
        end
      end
      T_ACK: begin
        if (!t_empty) begin
          tx_state_nx = T_IDLE;
        end else if (tx_tmo >= TMO_LAST) begin
          tx_timeout  = 1'b1;
          tx_state_nx = T_IDLE;
        end else if (tx_tmo != 8'hFF) begin
          tx_tmo_nx = tx_tmo + 8'd1;
        end
      end
      default: tx_state_nx = T_IDLE;
    endcase
  end

  // RX FSM: pulse rdn, capture byte and flags on the last strobe cycle.
  rx_state_t  rx_state;
  rx_state_t  rx_state_nx;
  logic [3:0] rx_stb;
  logic [3:0] rx_stb_nx;
  logic [7:0] rx_tmo;
  logic [7:0] rx_tmo_nx;
  logic       rdn_nx;
  logic       rx_timeout;

  always_ff @(posedge clk16x) begin
    if (clr) begin
      rx_state <= R_IDLE;
      rx_stb   <= '0;
      rx_tmo   <= '0;
      rdn      <= 1'b1;
    end else begin
      rx_state <= rx_state_nx;
      rx_stb   <= rx_stb_nx;
      rx_tmo   <= rx_tmo_nx;
      rdn      <= rdn_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_stb_nx   = rx_stb;
    rx_tmo_nx   = rx_tmo;
    rdn_nx      = rdn;
    rx_push     = 1'b0;
    rx_timeout  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (r_ready && !rx_full) begin
          rdn_nx      = 1'b0;
          rx_stb_nx   = '0;
          rx_state_nx = R_STB;
        end
      end
      R_STB: begin
        if (rx_stb == STB_LAST) begin
          rx_push     = 1'b1;
          rdn_nx      = 1'b1;
          rx_tmo_nx   = '0;
          rx_state_nx = R_ACK;
        end else begin
          rx_stb_nx = rx_stb + 4'd1;
        end
      end
      R_ACK: begin
        if (!r_ready) begin
          rx_state_nx = R_IDLE;
        end else if (rx_tmo >= TMO_LAST) begin
          rx_timeout  = 1'b1;
          rx_state_nx = R_IDLE;
        end else if (rx_tmo != 8'hFF) begin
          rx_tmo_nx = rx_tmo + 8'd1;
        end
      end
      default: rx_state_nx = R_IDLE;
    endcase
  end

  // Occupancy tracks user pushes against FSM pops.
  always_ff @(posedge clk16x) begin
    if (clr) begin
      tx_level <= '0;
    end else begin
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + (AW+1)'(1);
        2'b01:   tx_level <= tx_level - (AW+1)'(1);
        default: tx_level <= tx_level;
      endcase
    end
  end

  always_ff @(posedge clk16x) begin
    if (clr) begin
      tmo_err <= 1'b0;
    end else if (tx_timeout || rx_timeout) begin
      tmo_err <= 1'b1;
    end
  end
endmodule
